// File: rtl/dram_req_scheduler_if.sv
// Requester-side and command_FSM-side signals of the DRAM request scheduler.
// The slave modport is the scheduler; master is the requesters plus command_FSM.
interface dram_req_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int ROW_W  = 15,
  parameter int BANK_W = 4,
  parameter int COL_W  = 10
);
  localparam int ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_wen;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_done;
  logic [ID_W-1:0]        grant_id;
  logic [ADDR_W-1:0]      grant_addr;
  logic                   dREN;
  logic                   dWEN;
  logic [1:0]             row_stat;
  logic                   rf_req;
  logic                   acc_done;
  logic                   pre_done;
  logic                   ref_done;
  logic                   ref_ovf;

  modport master (
    output req_valid, req_wen, req_addr, acc_done, pre_done, ref_done,
    input  req_done, grant_id, grant_addr, dREN, dWEN, row_stat, rf_req, ref_ovf
  );

  modport slave (
    input  req_valid, req_wen, req_addr, acc_done, pre_done, ref_done,
    output req_done, grant_id, grant_addr, dREN, dWEN, row_stat, rf_req, ref_ovf
  );
endinterface

// File: rtl/dram_req_scheduler.sv
// Round-robin front end for command_FSM: one request in flight, open-row tracking
// per bank for HIT/MISS/CONFLICT, and refresh insertion at request boundaries.
module dram_req_scheduler #(
  parameter int NREQ       = 4,
  parameter int ROW_W      = 15,
  parameter int BANK_W     = 4,
  parameter int COL_W      = 10,
  parameter int REF_CYCLES = 6240
) (
  input  logic                CLK,
  input  logic                RST,
  dram_req_scheduler_if.slave bus
);
  localparam int ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NBANK  = 2 ** BANK_W;
  localparam int CNT_W  = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

  localparam logic [1:0] ST_HIT  = 2'b01;
  localparam logic [1:0] ST_MISS = 2'b10;
  localparam logic [1:0] ST_CONF = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_PRE, WAIT_ACC, REF_REQ, REF_WAIT} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     grant_id_reg;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ADDR_W-1:0]   grant_addr_reg;
  logic                wen_reg;
  logic [NBANK-1:0]    bank_valid_reg;
  logic [ROW_W-1:0]    bank_row_reg [NBANK];
  logic [CNT_W-1:0]    ref_cnt_reg;
  logic                rf_pending_reg;
  logic                ref_ovf_reg;

  logic [ADDR_W-1:0]   req_addr_arr [NREQ];
  logic [NREQ-1:0]     valid_rot;
  logic                arb_hit;
  logic [ID_W-1:0]     arb_id;
  logic [ID_W:0]       arb_sum;
  logic [ID_W-1:0]     rr_next;
  logic [ROW_W-1:0]    grant_row;
  logic [BANK_W-1:0]   grant_bank;
  logic [1:0]          row_cls;
  logic                ref_expire;
  logic                grant_take, issue, pre_take, acc_take, rf_issue, ref_take;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign bus.req_done[gi] = acc_take && (grant_id_reg == ID_W'(gi));
    end
  endgenerate

  // Rotate so bit k is requester (rr_ptr + k) mod NREQ; lowest set bit wins.
  assign valid_rot = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr_reg);

  always_comb begin
    arb_hit = 1'b0;
    arb_id  = '0;
    arb_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        arb_hit = 1'b1;
        arb_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
        if (arb_sum >= (ID_W+1)'(NREQ)) arb_sum = arb_sum - (ID_W+1)'(NREQ);
        arb_id  = arb_sum[ID_W-1:0];
      end
    end
  end

  assign rr_next    = (arb_id == ID_W'(NREQ - 1)) ? '0 : arb_id + 1'b1;
  assign grant_row  = grant_addr_reg[ADDR_W-1 -: ROW_W];
  assign grant_bank = grant_addr_reg[COL_W +: BANK_W];
  assign ref_expire = (ref_cnt_reg == CNT_W'(REF_CYCLES - 1));

  always_comb begin
    if (!bank_valid_reg[grant_bank])                row_cls = ST_MISS;
    else if (bank_row_reg[grant_bank] == grant_row) row_cls = ST_HIT;
    else                                            row_cls = ST_CONF;
  end

  always_comb begin
    state_next = state_reg;
    grant_take = 1'b0;
    issue      = 1'b0;
    pre_take   = 1'b0;
    acc_take   = 1'b0;
    rf_issue   = 1'b0;
    ref_take   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (rf_pending_reg) begin
          state_next = REF_REQ;
        end else if (arb_hit) begin
          grant_take = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue      = 1'b1;
        state_next = (row_cls == ST_CONF) ? WAIT_PRE : WAIT_ACC;
      end
      WAIT_PRE: begin
        if (bus.pre_done) begin
          pre_take   = 1'b1;
          state_next = ISSUE;
        end
      end
      WAIT_ACC: begin
        if (bus.acc_done) begin
          acc_take   = 1'b1;
          state_next = IDLE;
        end
      end
      REF_REQ: begin
        rf_issue   = 1'b1;
        state_next = REF_WAIT;
      end
      REF_WAIT: begin
        if (bus.ref_done) begin
          ref_take   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      grant_id_reg   <= '0;
      grant_addr_reg <= '0;
      wen_reg        <= 1'b0;
      rr_ptr_reg     <= '0;
      bank_valid_reg <= '0;
      ref_cnt_reg    <= '0;
      rf_pending_reg <= 1'b0;
      ref_ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_take) begin
        grant_id_reg   <= arb_id;
        grant_addr_reg <= req_addr_arr[arb_id];
        wen_reg        <= bus.req_wen[arb_id];
        rr_ptr_reg     <= rr_next;
      end
      if (pre_take) bank_valid_reg[grant_bank] <= 1'b0;
      if (acc_take) bank_valid_reg[grant_bank] <= 1'b1;
      if (ref_take) bank_valid_reg <= '0;
      // A new expiry outranks the clear in REF_REQ so no interval is lost.
      if (ref_expire) begin
        ref_cnt_reg    <= '0;
        rf_pending_reg <= 1'b1;
        if (rf_pending_reg) ref_ovf_reg <= 1'b1;
      end else begin
        ref_cnt_reg <= ref_cnt_reg + 1'b1;
        if (rf_issue) rf_pending_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (acc_take) bank_row_reg[grant_bank] <= grant_row;
  end

  assign bus.grant_id   = grant_id_reg;
  assign bus.grant_addr = grant_addr_reg;
  assign bus.dREN       = issue & ~wen_reg;
  assign bus.dWEN       = issue & wen_reg;
  assign bus.row_stat   = issue ? row_cls : 2'b00;
  assign bus.rf_req     = rf_issue;
  assign bus.ref_ovf    = ref_ovf_reg;
endmodule

// File: tb/tb_dram_req_scheduler.sv
// Directed bench for dram_req_scheduler: miss/hit/conflict, round-robin,
// refresh insertion and overflow, reset in the middle of an access.
module tb_dram_req_scheduler;
  localparam int NREQ       = 4;
  localparam int ROW_W      = 15;
  localparam int BANK_W     = 4;
  localparam int COL_W      = 10;
  localparam int REF_CYCLES = 16;
  localparam int AW         = ROW_W + BANK_W + COL_W;

  localparam logic [1:0] S_HIT  = 2'b01;
  localparam logic [1:0] S_MISS = 2'b10;
  localparam logic [1:0] S_CONF = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  dram_req_scheduler_if #(.NREQ(NREQ), .ROW_W(ROW_W), .BANK_W(BANK_W), .COL_W(COL_W)) bus ();

  dram_req_scheduler #(
    .NREQ(NREQ), .ROW_W(ROW_W), .BANK_W(BANK_W), .COL_W(COL_W), .REF_CYCLES(REF_CYCLES)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // cyc is 0 in the first cycle after the last reset edge.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input int row, input int bank, input int col);
    return {ROW_W'(row), BANK_W'(bank), COL_W'(col)};
  endfunction

  task automatic drive_req(input int id, input bit wen, input logic [AW-1:0] addr);
    bus.req_valid[id]         = 1'b1;
    bus.req_wen[id]           = wen;
    bus.req_addr[id*AW +: AW] = addr;
  endtask

  // Leaves the bench at the negedge of cycle 0 with reset released.
  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.acc_done  = 1'b0;
    bus.pre_done  = 1'b0;
    bus.ref_done  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".strobes"}, 32'({bus.dREN, bus.dWEN, bus.row_stat, bus.rf_req, bus.req_done, bus.ref_ovf}), 32'd0);
    check({tag, ".grant_id"}, 32'(bus.grant_id), 32'd0);
    check({tag, ".grant_addr"}, 32'(bus.grant_addr), 32'd0);
  endtask

  // Entered and left at the negedge of an IDLE cycle.
  task automatic access(input int id, input bit wen, input logic [AW-1:0] addr,
                        input logic [1:0] stat, input string tag);
    bus.acc_done  = 1'b0;
    bus.pre_done  = 1'b0;
    bus.req_valid = '0;
    drive_req(id, wen, addr);
    @(negedge clk);
    check({tag, ".row_stat"}, 32'(bus.row_stat), 32'(stat));
    check({tag, ".dREN"}, 32'(bus.dREN), 32'(!wen));
    check({tag, ".dWEN"}, 32'(bus.dWEN), 32'(wen));
    check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(id));
    check({tag, ".grant_addr"}, 32'(bus.grant_addr), 32'(addr));
    check({tag, ".rf_req"}, 32'(bus.rf_req), 32'd0);
    if (stat == S_CONF) begin
      @(negedge clk);
      check({tag, ".pre_wait_stat"}, 32'(bus.row_stat), 32'd0);
      bus.pre_done = 1'b1;
      @(negedge clk);
      bus.pre_done = 1'b0;
      check({tag, ".reissue_stat"}, 32'(bus.row_stat), 32'(S_MISS));
      check({tag, ".reissue_id"}, 32'(bus.grant_id), 32'(id));
    end
    @(negedge clk);
    check({tag, ".wait_strobes"}, 32'({bus.dREN, bus.dWEN, bus.row_stat}), 32'd0);
    check({tag, ".done_early"}, 32'(bus.req_done), 32'd0);
    bus.acc_done = 1'b1;
    #1;
    check({tag, ".req_done"}, 32'(bus.req_done), 32'(1 << id));
    @(negedge clk);
    bus.acc_done  = 1'b0;
    bus.req_valid = '0;
    #1;
    check({tag, ".done_pulse"}, 32'(bus.req_done), 32'd0);
    $display("txn %s: req%0d wen=%0d addr=0x%0h row_stat=%0b", tag, id, wen, addr, stat);
  endtask

  initial begin
    int  exp_rr[5];
    bit  found;
    bit  rf_seen;
    bit  saw_rf;

    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.acc_done  = 1'b0;
    bus.pre_done  = 1'b0;
    bus.ref_done  = 1'b0;

    // Miss, hit and conflict on bank 2, all inside the first refresh interval.
    do_reset();
    check_quiet("reset");
    access(0, 1'b0, mk_addr(5, 2, 3), S_MISS, "t1_read_miss");
    access(1, 1'b1, mk_addr(5, 2, 7), S_HIT,  "t2_write_hit");
    access(0, 1'b0, mk_addr(9, 2, 1), S_CONF, "t3_conflict");
    access(1, 1'b0, mk_addr(9, 2, 4), S_HIT,  "t3_row9_open");

    // All four requesters held; a refresh falls due before the fifth grant.
    do_reset();
    exp_rr = '{0, 1, 2, 3, 0};
    saw_rf = 1'b0;
    for (int i = 0; i < NREQ; i++) drive_req(i, 1'b0, mk_addr(i + 1, i, 0));
    for (int g = 0; g < 5; g++) begin
      found   = 1'b0;
      rf_seen = 1'b0;
      for (int t = 0; t < 30 && !found; t++) begin
        @(negedge clk);
        bus.ref_done = saw_rf;
        saw_rf       = bus.rf_req;
        if (bus.rf_req) rf_seen = 1'b1;
        if (bus.dREN) found = 1'b1;
      end
      check("t4.issue_seen", 32'(found), 32'd1);
      check("t4.grant_id", 32'(bus.grant_id), 32'(exp_rr[g]));
      check("t4.rf_before_grant", 32'(rf_seen), 32'(g == 4));
      $display("txn t4_rr: grant %0d -> req%0d", g, bus.grant_id);
      @(negedge clk);
      @(negedge clk);
      bus.acc_done = 1'b1;
      #1;
      check("t4.req_done", 32'(bus.req_done), 32'(1 << exp_rr[g]));
      @(negedge clk);
      bus.acc_done = 1'b0;
    end
    bus.req_valid = '0;
    bus.ref_done  = 1'b0;

    // Expiry at cycle 15 lands in WAIT_ACC; refresh goes ahead of req1.
    do_reset();
    goto(12);
    drive_req(0, 1'b0, mk_addr(9, 2, 0));
    goto(13);
    check("t5.first_stat", 32'(bus.row_stat), 32'(S_MISS));
    goto(16);
    check("t5.no_rf_in_wait", 32'(bus.rf_req), 32'd0);
    check("t5.done_early", 32'(bus.req_done), 32'd0);
    goto(17);
    bus.acc_done = 1'b1;
    #1;
    check("t5.req_done", 32'(bus.req_done), 32'b0001);
    goto(18);
    bus.acc_done  = 1'b0;
    bus.req_valid = '0;
    drive_req(1, 1'b0, mk_addr(9, 2, 5));
    check("t5.idle_rf", 32'(bus.rf_req), 32'd0);
    goto(19);
    check("t5.rf_req", 32'(bus.rf_req), 32'd1);
    check("t5.no_grant", 32'(bus.dREN), 32'd0);
    goto(20);
    check("t5.rf_one_cycle", 32'(bus.rf_req), 32'd0);
    bus.ref_done = 1'b1;
    goto(21);
    bus.ref_done = 1'b0;
    goto(22);
    check("t5.after_ref_stat", 32'(bus.row_stat), 32'(S_MISS));
    check("t5.after_ref_id", 32'(bus.grant_id), 32'd1);
    goto(23);
    bus.acc_done = 1'b1;
    #1;
    check("t5.req_done1", 32'(bus.req_done), 32'b0010);
    goto(24);
    bus.acc_done  = 1'b0;
    bus.req_valid = '0;
    $display("txn t5_refresh: access, refresh, access to bank2 row9");
    goto(33);
    check("t5.second_rf", 32'(bus.rf_req), 32'd1);
    goto(63);
    check("t5.ovf_clear", 32'(bus.ref_ovf), 32'd0);
    goto(64);
    check("t5.ovf_set", 32'(bus.ref_ovf), 32'd1);
    goto(66);
    bus.ref_done = 1'b1;
    goto(67);
    bus.ref_done = 1'b0;
    goto(68);
    check("t5.queued_rf", 32'(bus.rf_req), 32'd1);
    goto(69);
    bus.ref_done = 1'b1;
    goto(70);
    bus.ref_done = 1'b0;
    check("t5.ovf_sticky", 32'(bus.ref_ovf), 32'd1);
    $display("txn t5_overflow: ref_ovf=%0d", bus.ref_ovf);

    // Reset while WAIT_ACC: table is forgotten and a stale acc_done is dropped.
    do_reset();
    access(2, 1'b0, mk_addr(5, 2, 0), S_MISS, "t6_prime");
    drive_req(2, 1'b0, mk_addr(5, 2, 0));
    @(negedge clk);
    check("t6.hit_before_rst", 32'(bus.row_stat), 32'(S_HIT));
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    check_quiet("t6.after_rst");
    rst = 1'b0;
    drive_req(2, 1'b0, mk_addr(5, 2, 0));
    bus.acc_done = 1'b1;
    #1;
    check("t6.stale_acc", 32'(bus.req_done), 32'd0);
    @(negedge clk);
    bus.acc_done = 1'b0;
    check("t6.reissue_stat", 32'(bus.row_stat), 32'(S_MISS));
    check("t6.reissue_id", 32'(bus.grant_id), 32'd2);
    @(negedge clk);
    check("t6.done_early", 32'(bus.req_done), 32'd0);
    bus.acc_done = 1'b1;
    #1;
    check("t6.req_done", 32'(bus.req_done), 32'b0100);
    @(negedge clk);
    bus.acc_done  = 1'b0;
    bus.req_valid = '0;
    $display("txn t6_reset: reissue after reset row_stat=MISS");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
